// File: rtl/fetch_ctrl_pkg.sv
// Shared cache definitions: fetch command encodings, fetch engine state type
// and the line/word byte-offset helpers also used by rd_ctrl and wr_ctrl.
package fetch_ctrl_pkg;

    localparam logic [1:0] FETCH_WB   = 2'b00;
    localparam logic [1:0] FETCH_FILL = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB_RD   = 3'd1,
        ST_WB_WAIT = 3'd2,
        ST_WB_WR   = 3'd3,
        ST_FL_RD   = 3'd4,
        ST_FL_WAIT = 3'd5,
        ST_FL_WR   = 3'd6,
        ST_DONE    = 3'd7
    } fetch_state_t;

    // B: byte-offset bits inside one word
    function automatic int fetch_word_off(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // OFF: byte-offset bits inside one line
    function automatic int fetch_line_off(input int list_width, input int data_width);
        return $clog2(list_width * data_width / 8);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Line-fill / write-back engine: moves one cache line word by word between
// the local line memory and the external bus, one request at a time.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | fetch_gnt high, waiting for fetch_req
// WB_RD      | write-back: local read request for word wc
// WB_WAIT    | write-back: waiting for local read data
// WB_WR      | write-back: external write of captured word
// FL_RD      | fill: external read request for word wc
// FL_WAIT    | fill: waiting for external read data
// FL_WR      | fill: local write of captured word
// DONE       | one-cycle fetch_done pulse
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int data_width = 32,
    parameter int list_width = 32
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          fetch_req,
    output logic                                          fetch_gnt,
    input  logic [1:0]                                    fetch_cmd,
    input  logic [$clog2(list_depth)-1:0]                 fetch_tag,
    input  logic [addr_width-1:0]                         fetch_addr,
    output logic                                          fetch_done,
    output logic                                          mem_wen,
    output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_waddr,
    output logic [data_width-1:0]                         mem_wdata,
    input  logic                                          mem_wready,
    output logic                                          mem_ren,
    output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_raddr,
    output logic [1:0]                                    mem_rpri,
    input  logic                                          mem_rready,
    input  logic [data_width-1:0]                         mem_rdata,
    input  logic                                          mem_rdata_valid,
    output logic                                          ext_req,
    output logic                                          ext_we,
    output logic [addr_width-1:0]                         ext_addr,
    output logic [data_width-1:0]                         ext_wdata,
    input  logic                                          ext_gnt,
    input  logic [data_width-1:0]                         ext_rdata,
    input  logic                                          ext_rdata_valid
);

    localparam int TW  = $clog2(list_depth);
    localparam int WCW = $clog2(list_width);
    localparam int OFF = fetch_line_off(list_width, data_width);
    localparam int B   = fetch_word_off(data_width);
    localparam int AHW = addr_width - OFF;
    localparam logic [WCW-1:0] WC_LAST = WCW'(list_width - 1);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [WCW-1:0]        r_wc;
    logic [1:0]            r_cmd;
    logic [TW-1:0]         r_tag;
    logic [AHW-1:0]        r_addr;
    logic [data_width-1:0] r_data;

    logic                  w_handshake;
    logic                  w_last;
    logic                  w_advance;
    logic [TW+WCW-1:0]     w_laddr;
    logic [addr_width-1:0] w_ext_addr;
    logic                  w_unused_addr;

    assign w_handshake = fetch_req && (r_state == ST_IDLE);
    assign w_last      = (r_wc == WC_LAST);
    assign w_advance   = !w_last &&
                         (((r_state == ST_WB_WR) && ext_gnt) ||
                          ((r_state == ST_FL_WR) && mem_wready));

    // Line-aligned request: the in-line offset bits of fetch_addr carry no information.
    assign w_unused_addr = ^fetch_addr[OFF-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    case (fetch_cmd)
                        FETCH_WB:   w_state_nxt = ST_WB_RD;
                        FETCH_FILL: w_state_nxt = ST_FL_RD;
                        default:    w_state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_WB_RD:   if (mem_rready)      w_state_nxt = ST_WB_WAIT;
            ST_WB_WAIT: if (mem_rdata_valid) w_state_nxt = ST_WB_WR;
            ST_WB_WR:   if (ext_gnt)         w_state_nxt = w_last ? ST_DONE : ST_WB_RD;
            ST_FL_RD:   if (ext_gnt)         w_state_nxt = ST_FL_WAIT;
            ST_FL_WAIT: if (ext_rdata_valid) w_state_nxt = ST_FL_WR;
            ST_FL_WR:   if (mem_wready)      w_state_nxt = w_last ? ST_DONE : ST_FL_RD;
            ST_DONE:                         w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wc    <= '0;
            r_cmd   <= '0;
            r_tag   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_handshake) begin
                r_cmd  <= fetch_cmd;
                r_tag  <= fetch_tag;
                r_addr <= fetch_addr[addr_width-1:OFF];
                r_wc   <= '0;
            end else if (w_advance) begin
                r_wc <= r_wc + WCW'(1);
            end
            if ((r_state == ST_WB_WAIT) && mem_rdata_valid) begin
                r_data <= mem_rdata;
            end else if ((r_state == ST_FL_WAIT) && ext_rdata_valid) begin
                r_data <= ext_rdata;
            end
        end
    end

    assign w_laddr    = {r_tag, r_wc};
    assign w_ext_addr = addr_width'({r_addr, r_wc}) << B;

    assign fetch_gnt  = (r_state == ST_IDLE);
    assign fetch_done = (r_state == ST_DONE);
    assign mem_rpri   = 2'b01;

    assign mem_ren    = (r_state == ST_WB_RD);
    assign mem_raddr  = mem_ren ? w_laddr : '0;
    assign mem_wen    = (r_state == ST_FL_WR);
    assign mem_waddr  = mem_wen ? w_laddr : '0;
    assign mem_wdata  = mem_wen ? r_data : '0;

    assign ext_req    = (r_state == ST_WB_WR) || (r_state == ST_FL_RD);
    assign ext_we     = ext_req && (r_cmd == FETCH_WB);
    assign ext_addr   = ext_req ? w_ext_addr : '0;
    assign ext_wdata  = (r_state == ST_WB_WR) ? r_data : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with 4-word lines: bus responders check each
// transfer against expectations queued when the request is issued.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        fetch_gnt;
    logic [1:0]  fetch_cmd;
    logic [1:0]  fetch_tag;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic        mem_wen;
    logic [3:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready;
    logic        mem_ren;
    logic [3:0]  mem_raddr;
    logic [1:0]  mem_rpri;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic [31:0] ext_rdata;
    logic        ext_rdata_valid;

    fetch_ctrl #(
        .addr_width(32), .list_depth(4), .data_width(32), .list_width(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_cmd(fetch_cmd),
        .fetch_tag(fetch_tag), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wready(mem_wready), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .mem_rpri(mem_rpri), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
        .ext_rdata_valid(ext_rdata_valid)
    );

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } ext_t;
    typedef struct { logic [3:0] addr; logic [31:0] data; } memw_t;

    ext_t        exp_ext[$];
    memw_t       exp_memw[$];
    logic [3:0]  exp_memr[$];
    logic [31:0] lmem [16];

    int          total = 0;
    int          bad = 0;
    int          n_xact = 0;
    int          n_done = 0;
    int          ext_stall = 0;
    int          memw_stall = 0;
    bit          ext_pend = 0;
    bit          mem_pend = 0;
    logic [31:0] ext_pend_d;
    logic [31:0] mem_pend_d;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ext_word(input logic [31:0] a);
        return a * 32'd3 + 32'h1111_0000;
    endfunction

    function automatic void push_fill(input logic [1:0] tag, input logic [31:0] base);
        for (int w = 0; w < 4; w++) begin
            exp_ext.push_back('{1'b0, base + 32'(4 * w), 32'h0});
            exp_memw.push_back('{{tag, 2'(w)}, ext_word(base + 32'(4 * w))});
        end
    endfunction

    function automatic void push_wb(input logic [1:0] tag, input logic [31:0] base);
        for (int w = 0; w < 4; w++) begin
            exp_memr.push_back({tag, 2'(w)});
            exp_ext.push_back('{1'b1, base + 32'(4 * w), lmem[{tag, 2'(w)}]});
        end
    endfunction

    // External bus model: optional grant stall, read data one cycle after grant,
    // junk valid strobes whenever no read data is owed.
    initial begin
        ext_t e;
        ext_gnt = 0; ext_rdata_valid = 0; ext_rdata = '0;
        forever begin
            @(negedge clk);
            ext_gnt = 0;
            ext_rdata_valid = 0;
            ext_rdata = '0;
            if (ext_pend) begin
                ext_rdata_valid = 1;
                ext_rdata = ext_pend_d;
                ext_pend = 0;
            end else begin
                ext_rdata_valid = 1;
                ext_rdata = 32'hBAD0_0E0E;
            end
            if (ext_req === 1'b1) begin
                e = (exp_ext.size() > 0) ? exp_ext[0] : '{1'bx, 32'hx, 32'hx};
                total++;
                if (ext_stall > 0) begin
                    ext_stall--;
                    if (ext_addr !== e.addr || ext_we !== e.we || (e.we && ext_wdata !== e.data)) begin
                        bad++;
                        $display("FAIL ext_stall_stable got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                                 ext_we, ext_addr, ext_wdata, e.we, e.addr, e.data);
                    end
                end else begin
                    ext_gnt = 1;
                    n_xact++;
                    if (exp_ext.size() > 0) void'(exp_ext.pop_front());
                    if (ext_addr !== e.addr || ext_we !== e.we || (e.we && ext_wdata !== e.data)) begin
                        bad++;
                        $display("FAIL ext_xfer got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                                 ext_we, ext_addr, ext_wdata, e.we, e.addr, e.data);
                    end
                    if (ext_we === 1'b0) begin
                        ext_pend = 1;
                        ext_pend_d = ext_word(ext_addr);
                    end
                end
            end
        end
    end

    // Local line memory model: reads accepted at once, optional write-accept stall.
    initial begin
        memw_t m;
        logic [3:0] ra;
        mem_rready = 0; mem_wready = 0; mem_rdata_valid = 0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rready = 0;
            mem_wready = 0;
            mem_rdata_valid = 0;
            mem_rdata = '0;
            if (mem_pend) begin
                mem_rdata_valid = 1;
                mem_rdata = mem_pend_d;
                mem_pend = 0;
            end else begin
                mem_rdata_valid = 1;
                mem_rdata = 32'hBAD0_0D0D;
            end
            if (mem_ren === 1'b1) begin
                mem_rready = 1;
                n_xact++;
                total++;
                ra = (exp_memr.size() > 0) ? exp_memr.pop_front() : 4'hx;
                if (mem_raddr !== ra) begin
                    bad++;
                    $display("FAIL mem_read got raddr=%0d exp raddr=%0d", mem_raddr, ra);
                end
                mem_pend = 1;
                mem_pend_d = lmem[mem_raddr];
            end
            if (mem_wen === 1'b1) begin
                m = (exp_memw.size() > 0) ? exp_memw[0] : '{4'hx, 32'hx};
                total++;
                if (memw_stall > 0) begin
                    memw_stall--;
                    if (mem_waddr !== m.addr || mem_wdata !== m.data) begin
                        bad++;
                        $display("FAIL mem_stall_stable got waddr=%0d wdata=%h exp waddr=%0d wdata=%h",
                                 mem_waddr, mem_wdata, m.addr, m.data);
                    end
                end else begin
                    mem_wready = 1;
                    n_xact++;
                    if (exp_memw.size() > 0) void'(exp_memw.pop_front());
                    if (mem_waddr !== m.addr || mem_wdata !== m.data) begin
                        bad++;
                        $display("FAIL mem_write got waddr=%0d wdata=%h exp waddr=%0d wdata=%h",
                                 mem_waddr, mem_wdata, m.addr, m.data);
                    end
                    lmem[mem_waddr] = mem_wdata;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fetch_done === 1'b1) n_done++;
        end
    end

    task automatic check_reset_outputs(input string nm);
        total++;
        if ({fetch_gnt, fetch_done, mem_wen, mem_ren, ext_req, ext_we, mem_rpri} !== 8'b1000_0001) begin
            bad++;
            $display("FAIL %s_ctrl got %b exp 10000001", nm,
                     {fetch_gnt, fetch_done, mem_wen, mem_ren, ext_req, ext_we, mem_rpri});
        end
        total++;
        if ({ext_addr, ext_wdata, mem_wdata, mem_waddr, mem_raddr} !== 104'h0) begin
            bad++;
            $display("FAIL %s_data got ext_addr=%h ext_wdata=%h mem_wdata=%h waddr=%0d raddr=%0d exp all 0",
                     nm, ext_addr, ext_wdata, mem_wdata, mem_waddr, mem_raddr);
        end
    endtask

    task automatic wait_done(output int n, output logic g);
        n = -1;
        g = 1'bx;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (fetch_done === 1'b1) begin
                n = i;
                g = fetch_gnt;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] cmd, input logic [1:0] tag, input logic [31:0] addr,
                          input int exp_lat, input int exp_x, input string nm);
        int n, d0, x0;
        logic g;
        @(negedge clk);
        total++;
        if (fetch_gnt !== 1'b1) begin
            bad++;
            $display("FAIL %s_gnt_idle got %b exp 1", nm, fetch_gnt);
        end
        fetch_req = 1; fetch_cmd = cmd; fetch_tag = tag; fetch_addr = addr;
        d0 = n_done;
        x0 = n_xact;
        @(posedge clk);
        #1 fetch_req = 0;
        wait_done(n, g);
        total++;
        if (n !== exp_lat) begin
            bad++;
            $display("FAIL %s_latency got %0d exp %0d", nm, n, exp_lat);
        end
        total++;
        if (g !== 1'b0) begin
            bad++;
            $display("FAIL %s_gnt_in_done got %b exp 0", nm, g);
        end
        @(negedge clk);
        total++;
        if ({fetch_done, fetch_gnt} !== 2'b01 || n_done - d0 !== 1) begin
            bad++;
            $display("FAIL %s_done_once got done=%b gnt=%b pulses=%0d exp done=0 gnt=1 pulses=1",
                     nm, fetch_done, fetch_gnt, n_done - d0);
        end
        total++;
        if (n_xact - x0 !== exp_x || exp_ext.size() + exp_memw.size() + exp_memr.size() !== 0) begin
            bad++;
            $display("FAIL %s_traffic got xfers=%0d left=%0d exp xfers=%0d left=0", nm, n_xact - x0,
                     exp_ext.size() + exp_memw.size() + exp_memr.size(), exp_x);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        fetch_req = 0; fetch_cmd = '0; fetch_tag = '0; fetch_addr = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_fill();
        push_fill(2'd2, 32'h0000_1040);
        run_op(2'b01, 2'd2, 32'h0000_1040, 13, 8, "fill");
    endtask

    task automatic test_writeback();
        for (int i = 0; i < 4; i++) lmem[4 + i] = 32'hA000_00A0 + 32'(i);
        push_wb(2'd1, 32'h0000_2000);
        run_op(2'b00, 2'd1, 32'h0000_2000, 13, 8, "wb");
    endtask

    task automatic test_backpressure();
        push_fill(2'd3, 32'h0000_3000);
        ext_stall = 5;
        memw_stall = 3;
        run_op(2'b01, 2'd3, 32'h0000_3000, 21, 8, "bp");
        total++;
        if (ext_stall !== 0 || memw_stall !== 0) begin
            bad++;
            $display("FAIL bp_stalls_used got ext=%0d mem=%0d exp 0 0", ext_stall, memw_stall);
        end
    endtask

    task automatic test_reserved();
        run_op(2'b10, 2'd0, 32'h0000_5000, 1, 0, "rsv");
    endtask

    task automatic test_back_to_back();
        int n, gbad;
        logic g;
        push_fill(2'd2, 32'h0000_1100);
        @(negedge clk);
        fetch_req = 1; fetch_cmd = 2'b01; fetch_tag = 2'd2; fetch_addr = 32'h0000_1100;
        @(posedge clk);
        #1;
        fetch_tag = 2'd3;
        fetch_addr = 32'h0000_1180;
        push_fill(2'd3, 32'h0000_1180);
        n = -1;
        gbad = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (fetch_done === 1'b1) begin
                n = i;
                break;
            end
            if (fetch_gnt !== 1'b0) gbad++;
        end
        total++;
        if (n !== 13 || gbad !== 0) begin
            bad++;
            $display("FAIL b2b_first got latency=%0d early_gnt=%0d exp 13 0", n, gbad);
        end
        @(negedge clk);
        total++;
        if (fetch_gnt !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gnt_after_done got %b exp 1", fetch_gnt);
        end
        @(posedge clk);
        #1 fetch_req = 0;
        wait_done(n, g);
        total++;
        if (n !== 13) begin
            bad++;
            $display("FAIL b2b_second_latency got %0d exp 13", n);
        end
        @(negedge clk);
        total++;
        if (exp_ext.size() + exp_memw.size() !== 0) begin
            bad++;
            $display("FAIL b2b_traffic got left=%0d exp 0", exp_ext.size() + exp_memw.size());
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit found;
        push_fill(2'd2, 32'h0000_1200);
        @(negedge clk);
        fetch_req = 1; fetch_cmd = 2'b01; fetch_tag = 2'd2; fetch_addr = 32'h0000_1200;
        @(posedge clk);
        #1 fetch_req = 0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ext_req === 1'b1 && ext_addr === 32'h0000_1208) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rmid_reach_wc2 got not_seen exp ext read at 00001208");
        end
        d0 = n_done;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check_reset_outputs("rmid");
        exp_ext.delete();
        exp_memw.delete();
        exp_memr.delete();
        ext_pend = 0;
        mem_pend = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        total++;
        if (n_done !== d0) begin
            bad++;
            $display("FAIL rmid_no_done got pulses=%0d exp 0", n_done - d0);
        end
        push_fill(2'd1, 32'h0000_6000);
        run_op(2'b01, 2'd1, 32'h0000_6000, 13, 8, "rmid_after");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lmem[i] = '0;
        test_reset();
        test_fill();
        test_writeback();
        test_backpressure();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Line-fill and write-back engine that answers the cache controllers' fetch request interface (fetch_req/fetch_gnt/fetch_done).
- Moves one whole cache line, word by word, between the local line data memory (addressed by list tag + word offset) and the external memory bus.
- Sits between the rd/wr controllers and the off-cache memory. Serves one request at a time.

Parameters:
addr_width, 32, byte address width
list_depth, 4, number of cache lines (tag width = $clog2(list_depth))
data_width, 32, word width in bits; must be a multiple of 8
list_width, 32, words per line (power of two)

Ports:
clk  input  1  clock
rst_n  input  1  reset
fetch_req  input  1  request valid from the cache controller
fetch_gnt  output  1  request accepted; 1 only in IDLE
fetch_cmd  input  2  00 write-back line, 01 fill line, 10/11 reserved
fetch_tag  input  $clog2(list_depth)  local line slot
fetch_addr  input  addr_width  line-aligned external byte address
fetch_done  output  1  one-cycle completion pulse
mem_wen  output  1  local write request
mem_waddr  output  $clog2(list_depth)+$clog2(list_width)  {tag, word}
mem_wdata  output  data_width  local write data
mem_wready  input  1  local write accepted
mem_ren  output  1  local read request
mem_raddr  output  $clog2(list_depth)+$clog2(list_width)  {tag, word}
mem_rpri  output  2  read priority, constant 2'b01
mem_rready  input  1  local read accepted
mem_rdata  input  data_width  local read data
mem_rdata_valid  input  1  local read data valid (any latency ≥1 after accept)
ext_req  output  1  external bus request
ext_we  output  1  1 = write, 0 = read
ext_addr  output  addr_width  external word byte address
ext_wdata  output  data_width  external write data
ext_gnt  input  1  external request accepted
ext_rdata  input  data_width  external read data
ext_rdata_valid  input  1  external read data valid (any latency ≥1 after grant)

Behaviour:
- Interface decision: single clock clk; reset rst_n is asynchronous, active-low.
- Reset:
  - State goes to IDLE; word counter, latched cmd/tag/addr and data register clear to 0.
  - All outputs are 0 except fetch_gnt (1) and mem_rpri (01).
- Handshake and latching:
  - fetch_gnt = (state==IDLE).
  - On fetch_req && fetch_gnt, latch cmd, tag and addr, clear the word counter (wc), and move to the next state in the same edge.
  - fetch_* inputs are ignored outside IDLE.
- Addressing:
  - ext_addr = {addr_ff[aw-1:OFF], wc, B zero bits}, where OFF = $clog2(list_width*data_width/8) and B = $clog2(data_width/8).
  - mem_raddr = mem_waddr = {tag_ff, wc}.
  - Request outputs are zero when their request is inactive.
- States (Moore outputs): IDLE, WB_RD, WB_WAIT, WB_WR, FL_RD, FL_WAIT, FL_WR, DONE.
- IDLE:
  - On handshake: cmd 00 goes to WB_RD, cmd 01 goes to FL_RD, cmd 1x goes to DONE.
- Write-back path (cmd 00):
  - WB_RD: mem_ren=1; on mem_rready go to WB_WAIT.
  - WB_WAIT: on mem_rdata_valid, capture mem_rdata into data_ff and go to WB_WR.
  - WB_WR: ext_req=1, ext_we=1, ext_wdata=data_ff. On ext_gnt: if wc==list_width-1 go to DONE, else wc+1 and go to WB_RD.
- Fill path (cmd 01):
  - FL_RD: ext_req=1, ext_we=0; on ext_gnt go to FL_WAIT.
  - FL_WAIT: on ext_rdata_valid, capture ext_rdata into data_ff and go to FL_WR.
  - FL_WR: mem_wen=1, mem_wdata=data_ff. On mem_wready: last word goes to DONE, else wc+1 and go to FL_RD.
- DONE: fetch_done=1 for exactly one cycle, then IDLE. A new request can be granted in the cycle after DONE at the earliest.
- Stalls: any request held indefinitely while its ready/gnt is low; address and data remain stable.
- Spurious strobes: mem_rdata_valid / ext_rdata_valid outside the matching WAIT state are ignored.
- Counter: wc is $clog2(list_width) bits. It never wraps mid-line; the last word is detected by compare, not by overflow.
- Latency: minimum 3*list_width+1 cycles from grant to done when all ready/valid responses are single-cycle.
- Reset mid-operation: abort immediately with no fetch_done; a partially written line is the requester's responsibility.

Decomposition:
- Shared cache package: fetch_cmd encoding constants (FETCH_WB=2'b00, FETCH_FILL=2'b01) and the fetch_state_t enum.
- The same package holds the OFF/B offset localparam expressions shared with rd_ctrl/wr_ctrl.
- No sub-module; the datapath is a single counter plus one data register.

Test Plan:
- Fill, list_width=4, tag=2, addr=0x1040, all responses single-cycle:
  - ext reads go to 0x1040, 0x1044, 0x1048, 0x104C with ext_we=0.
  - Local writes go to mem_waddr 8, 9, 10, 11 carrying the returned data.
  - fetch_done pulses exactly once, 13 cycles after grant.
- Write-back, tag=1, addr=0x2000, local data A0..A3:
  - mem_raddr goes 4..7.
  - ext writes carry 0x2000/A0 through 0x200C/A3 with ext_we=1.
  - One fetch_done pulse.
- Backpressure: hold ext_gnt low for 5 cycles and mem_wready low for 3.
  - Request, address and data stay stable throughout.
  - No word is skipped or duplicated; done is delayed by exactly 8 cycles.
- Reserved cmd 2'b10:
  - No mem/ext traffic; fetch_done the cycle after grant; fetch_gnt=0 during DONE.
- Second fetch_req held high during a fill:
  - fetch_gnt stays 0 until the cycle after done.
  - The second request is latched with its own tag/addr.
- Assert rst_n low mid-fill (wc=2):
  - All outputs return to reset values asynchronously; no fetch_done.
  - A following request executes cleanly from wc=0.
